// File: rtl/uart_param_if.sv
// uart_param_if: TX/RX stream and status signals of uart_param.
// The slave modport is the UART side, master is the user side.
interface uart_param_if;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_tx;
  logic       i_rx;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic       o_rx_parity_error;
  logic       o_rx_frame_error;
  logic       o_rx_overrun;

  modport slave (
    input  i_tx_data, i_tx_valid,
    input  i_rx, i_rx_ready,
    output o_tx_ready, o_tx,
    output o_rx_data, o_rx_valid,
    output o_rx_parity_error,
    output o_rx_frame_error,
    output o_rx_overrun
  );

  modport master (
    output i_tx_data, i_tx_valid,
    output i_rx, i_rx_ready,
    input  o_tx_ready, o_tx,
    input  o_rx_data, o_rx_valid,
    input  o_rx_parity_error,
    input  o_rx_frame_error,
    input  o_rx_overrun
  );
endinterface

// File: rtl/uart_param.sv
// uart_param: parameterised UART, TX and RX share one oversample tick.
// Define UART_PARAM_RX_FIFO_EN for a 4-entry RX FIFO with overrun flag.
module uart_param #(
  parameter int CLK_DIV    = 108,
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input logic         clk,
  input logic         rst,
  uart_param_if.slave u
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [11:0] DIV_M1 = 12'(CLK_DIV - 1);
  localparam logic [3:0]  OS_M1  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  OS_H1  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]  DB_M1  = 3'(DATA_BITS - 1);
  localparam logic [7:0]  MASK   = 8'((1 << DATA_BITS) - 1);
  localparam logic        ODD    = (PARITY == 2);
  localparam logic        SB_M1  = 1'(STOP_BITS - 1);

  logic [11:0] div_q;
  logic        tick;

  assign tick = (div_q == DIV_M1);

  always_ff @(posedge clk or posedge rst)
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 12'd1;

  logic [2:0] tx_st_q, tx_st_d;
  logic [3:0] tx_os_q, tx_os_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_par_q, tx_par_d;
  logic       tx_line_q, tx_line_d;
  logic       tx_arm_q, tx_arm_d;
  logic       tx_stp_q, tx_stp_d;

  // arm holds the line high until the next tick so the start bit is full width
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_os_d   = tx_os_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_line_d = tx_line_q;
    tx_arm_d  = tx_arm_q;
    tx_stp_d  = tx_stp_q;
    if (tx_st_q == S_IDLE) begin
      tx_line_d = 1'b1;
      if (u.i_tx_valid) begin
        tx_st_d  = S_START;
        tx_arm_d = 1'b1;
        tx_sh_d  = u.i_tx_data & MASK;
        tx_par_d = (^(u.i_tx_data & MASK)) ^ ODD;
      end
    end else if (tick) begin
      if (tx_arm_q) begin
        tx_arm_d  = 1'b0;
        tx_os_d   = '0;
        tx_line_d = 1'b0;
      end else if (tx_os_q != OS_M1) begin
        tx_os_d = tx_os_q + 4'd1;
      end else begin
        tx_os_d = '0;
        unique case (1'b1)
          (tx_st_q == S_START): begin
            tx_st_d   = S_DATA;
            tx_bit_d  = '0;
            tx_line_d = tx_sh_q[0];
          end
          (tx_st_q == S_DATA): begin
            if (tx_bit_q != DB_M1) begin
              tx_bit_d  = tx_bit_q + 3'd1;
              tx_sh_d   = tx_sh_q >> 1;
              tx_line_d = tx_sh_q[1];
            end else if (PARITY != 0) begin
              tx_st_d   = S_PAR;
              tx_line_d = tx_par_q;
            end else begin
              tx_st_d   = S_STOP;
              tx_stp_d  = 1'b0;
              tx_line_d = 1'b1;
            end
          end
          (tx_st_q == S_PAR): begin
            tx_st_d   = S_STOP;
            tx_stp_d  = 1'b0;
            tx_line_d = 1'b1;
          end
          default: begin
            if (tx_stp_q == SB_M1) tx_st_d = S_IDLE;
            else                   tx_stp_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q   <= S_IDLE;
      tx_os_q   <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_line_q <= 1'b1;
      tx_arm_q  <= 1'b0;
      tx_stp_q  <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_os_q   <= tx_os_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_line_q <= tx_line_d;
      tx_arm_q  <= tx_arm_d;
      tx_stp_q  <= tx_stp_d;
    end

  assign u.o_tx_ready = (tx_st_q == S_IDLE);
  assign u.o_tx       = tx_line_q;

  logic       rx_s1_q, rx_s2_q;
  logic [2:0] rx_st_q, rx_st_d;
  logic [3:0] rx_os_q, rx_os_d;
  logic [3:0] rx_lim;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_pe_q, rx_pe_d;
  logic       rx_done;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_os_d  = rx_os_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_pe_d  = rx_pe_q;
    rx_done  = 1'b0;
    rx_lim   = (rx_st_q == S_START) ? OS_H1 : OS_M1;
    if (rx_st_q == S_IDLE) begin
      if (!rx_s2_q) begin
        rx_st_d = S_START;
        rx_os_d = '0;
        rx_sh_d = '0;
        rx_pe_d = 1'b0;
      end
    end else if (tick) begin
      if (rx_os_q != rx_lim) begin
        rx_os_d = rx_os_q + 4'd1;
      end else begin
        rx_os_d = '0;
        unique case (1'b1)
          (rx_st_q == S_START): begin
            rx_bit_d = '0;
            rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
          end
          (rx_st_q == S_DATA): begin
            rx_sh_d[rx_bit_q] = rx_s2_q;
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == DB_M1)
              rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
          (rx_st_q == S_PAR): begin
            rx_pe_d = (^rx_sh_q) ^ rx_s2_q ^ ODD;
            rx_st_d = S_STOP;
          end
          default: begin
            rx_done = 1'b1;
            rx_st_d = S_IDLE;
          end
        endcase
      end
    end
  end

  logic perr_q, ferr_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_os_q  <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rx_pe_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_s1_q  <= u.i_rx;
      rx_s2_q  <= rx_s1_q;
      rx_st_q  <= rx_st_d;
      rx_os_q  <= rx_os_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_pe_q  <= rx_pe_d;
      if (rx_done) begin
        perr_q <= rx_pe_q;
        ferr_q <= !rx_s2_q;
      end
    end

  assign u.o_rx_parity_error = perr_q;
  assign u.o_rx_frame_error  = ferr_q;

`ifdef UART_PARAM_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q;
  logic       ovr_q;
  logic       full, pop, push;

  assign full = (cnt_q == 3'd4);
  assign pop  = (cnt_q != 3'd0) && u.i_rx_ready;
  // a full FIFO still takes a frame when the same edge pops one
  assign push = rx_done && (!full || pop);

  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= rx_sh_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 2'd1;
      if (pop)  rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
      if (rx_done && !push) ovr_q <= 1'b1;
    end

  assign u.o_rx_valid   = (cnt_q != 3'd0);
  assign u.o_rx_data    = u.o_rx_valid ? mem_q[rp_q] : 8'h00;
  assign u.o_rx_overrun = ovr_q;
`else
  logic [7:0] dat_q;
  logic       vld_q;
  logic       unused_rdy;

  assign unused_rdy = u.i_rx_ready;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rx_done;
      if (rx_done) dat_q <= rx_sh_q;
    end

  assign u.o_rx_valid   = vld_q;
  assign u.o_rx_data    = dat_q;
  assign u.o_rx_overrun = 1'b0;
`endif
endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter CLK_DIV, 108, clk cycles per oversample tick; legal range 2..4095.
REQ-002 Parameter OVERSAMPLE, 4, ticks per bit; legal values 4, 8, 16.
REQ-003 Parameter DATA_BITS, 8, data bits per frame; legal range 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame; legal values 1, 2.
REQ-006 clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 i_tx_data  input  8  TX byte; bits above DATA_BITS-1 ignored.
REQ-009 i_tx_valid  input  1  TX request.
REQ-010 o_tx_ready  output  1  TX idle, can accept a byte.
REQ-011 o_tx  output  1  serial line out.
REQ-012 i_rx  input  1  serial line in, asynchronous.
REQ-013 o_rx_data  output  8  received byte, zero-extended above DATA_BITS.
REQ-014 o_rx_valid  output  1  received byte available.
REQ-015 i_rx_ready  input  1  consumer accepts o_rx_data.
REQ-016 o_rx_parity_error  output  1  parity mismatch on last frame.
REQ-017 o_rx_frame_error  output  1  stop bit sampled low on last frame.
REQ-018 o_rx_overrun  output  1  sticky, byte dropped for lack of space.

Function
REQ-019 Free-running tick counter SHALL count 0..CLK_DIV-1 and assert a one-cycle tick at CLK_DIV-1; TX and RX share it.
REQ-020 Frames SHALL be: start (0), DATA_BITS LSB first, optional parity, STOP_BITS stop (1); each bit lasts OVERSAMPLE ticks.
REQ-021 TX states: IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-022 Byte accepted on the clk edge where i_tx_valid and o_tx_ready are both 1; o_tx_ready drops the next cycle and stays low until the final stop bit ends.
REQ-023 o_tx SHALL go low within CLK_DIV*OVERSAMPLE cycles of acceptance and otherwise hold 1 in IDLE.
REQ-024 i_tx_valid while o_tx_ready=0 SHALL be ignored; i_tx_data is sampled only at acceptance.
REQ-025 i_rx SHALL pass a 2-flop synchroniser before any use.
REQ-026 RX states: IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-027 IDLE->START on synchronised low; line re-sampled after OVERSAMPLE/2 ticks; high returns to IDLE with no output, no error (glitch reject).
REQ-028 Data, parity and stop bits SHALL be sampled every OVERSAMPLE ticks after the start mid-point.
REQ-029 Only the first stop bit is checked; low sets o_rx_frame_error, byte still delivered.
REQ-030 Even parity: ones in data plus parity bit is even; odd parity: odd; mismatch sets o_rx_parity_error.
REQ-031 Error flags SHALL update at every frame completion and hold until the next completion.
REQ-032 After the first stop-bit sample RX returns to IDLE at once, so back-to-back frames are received without loss.

Reset
REQ-033 rst=1 SHALL immediately force: o_tx=1, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, all error flags 0, both FSMs IDLE, tick counter 0, FIFO (if present) empty.
REQ-034 Reset mid-frame SHALL abort the frame; the partial byte is never delivered and TX resumes from IDLE with o_tx=1.

Configuration
REQ-035 With UART_PARAM_RX_FIFO_EN defined: 4-entry RX FIFO; o_rx_valid=1 while non-empty; entry popped on edge where o_rx_valid and i_rx_ready are 1; a frame completing while full is dropped and sets o_rx_overrun until reset; push and pop in the same cycle when full SHALL succeed.
REQ-036 Without UART_PARAM_RX_FIFO_EN: single output register; o_rx_valid is a one-cycle pulse at frame completion; o_rx_data holds until the next frame; i_rx_ready ignored; o_rx_overrun tied 0.

Verification
REQ-037 Defaults, loop o_tx to i_rx, send 8'hA5 -> o_tx low for 432 cycles, o_tx_ready low about 4320 cycles, o_rx_data=8'hA5, no errors.
REQ-038 PARITY=1, DATA_BITS=7, send 7'h55 -> parity bit 0 on line, received 8'h55; flip parity bit on line -> o_rx_parity_error=1.
REQ-039 i_rx low for 100 cycles, then high -> no o_rx_valid, RX back in IDLE.
REQ-040 Frame with stop bit forced low, byte 8'h3C -> o_rx_data=8'h3C, o_rx_frame_error=1; next clean frame clears it.
REQ-041 FIFO build, i_rx_ready=0, 5 frames 8'h01..8'h05 -> 4 entries 8'h01..8'h04 read out, o_rx_overrun=1.
REQ-042 Assert rst mid-byte on both TX and RX -> o_tx=1, o_tx_ready=1 the same cycle, no o_rx_valid; next 8'h5A transfers cleanly.
